// File: rtl/move_sched_if.sv
// Command/response signal bundle between the UART side, move_sched and cmd_proc.
interface move_sched_if;
  logic [15:0] rx_cmd;
  logic        rx_cmd_rdy;
  logic        rx_clr;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;
  logic        resp_vld;
  logic        fault;
  logic [3:0]  occ;

  modport master (
    output rx_cmd, rx_cmd_rdy, clr_cmd_rdy, send_resp,
    input  rx_clr, cmd, cmd_rdy, resp, resp_vld, fault, occ
  );
  modport slave (
    input  rx_cmd, rx_cmd_rdy, clr_cmd_rdy, send_resp,
    output rx_clr, cmd, cmd_rdy, resp, resp_vld, fault, occ
  );
endinterface

// File: rtl/move_sched.sv
// Move command queue: buffers host commands, issues them one at a time to cmd_proc,
// produces response bytes, times out stalled moves and honours the abort opcode.
module move_sched #(
  parameter int DEPTH    = 4,
  parameter int TMO_CLKS = 50_000_000
) (
  input logic        clk,
  input logic        rst_n,
  move_sched_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state_q, state_d;

  logic [DEPTH-1:0][15:0] mem;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [3:0]    occ_q;
  logic [25:0]   timer;
  logic          pend_vld;
  logic [7:0]    pend;
  logic          rx_clr_q, cmd_rdy_q, resp_vld_q, fault_q;
  logic [15:0]   cmd_q;
  logic [7:0]    resp_q;

  logic take, is_abort, full, push, ovf, flush, post;
  logic load, pop, withdraw, done, tmo;

  assign take     = bus.rx_cmd_rdy & ~rx_clr_q;
  assign is_abort = take & (bus.rx_cmd[15:12] == 4'hF);
  assign full     = (occ_q == 4'(DEPTH));
  assign ovf      = take & ~is_abort & full;
  // A timeout flush also discards a word arriving on the same edge.
  assign push     = take & ~is_abort & ~full & ~tmo;
  assign flush    = is_abort | tmo;
  assign post     = is_abort | ovf;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    pop      = 1'b0;
    withdraw = 1'b0;
    done     = 1'b0;
    tmo      = 1'b0;
    case (state_q)
      IDLE: if (occ_q != 4'd0 && !is_abort) begin
        load    = 1'b1;
        state_d = ISSUE;
      end
      ISSUE: if (bus.clr_cmd_rdy) begin
        pop     = 1'b1;
        state_d = WAIT;
      end else if (is_abort) begin
        withdraw = 1'b1;
        state_d  = IDLE;
      end
      WAIT: if (bus.send_resp) begin
        done    = 1'b1;
        state_d = IDLE;
      end else if (timer == 26'(TMO_CLKS)) begin
        tmo     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;

  // Storage carries no reset; occupancy decides what is valid.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.rx_cmd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= 4'd0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ_q  <= 4'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 4'd1;
        2'b01:   occ_q <= occ_q - 4'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_clr_q   <= 1'b0;
      cmd_q      <= 16'h0000;
      cmd_rdy_q  <= 1'b0;
      timer      <= 26'd0;
      fault_q    <= 1'b0;
      resp_q     <= 8'h00;
      resp_vld_q <= 1'b0;
      pend_vld   <= 1'b0;
      pend       <= 8'h00;
    end else begin
      rx_clr_q <= take;
      if (load) begin
        cmd_q     <= mem[rd_ptr];
        cmd_rdy_q <= 1'b1;
      end else if (pop || withdraw) begin
        cmd_rdy_q <= 1'b0;
      end
      if (pop)                  timer <= 26'd0;
      else if (state_q == WAIT) timer <= timer + 26'd1;
      if (tmo)       fault_q <= 1'b1;
      else if (push) fault_q <= 1'b0;
      // Completion/timeout bytes pre-empt the single pending slot.
      if (done) begin
        resp_q     <= 8'hA5;
        resp_vld_q <= 1'b1;
      end else if (tmo) begin
        resp_q     <= 8'hE2;
        resp_vld_q <= 1'b1;
      end else if (pend_vld) begin
        resp_q     <= pend;
        resp_vld_q <= 1'b1;
      end else begin
        resp_vld_q <= 1'b0;
      end
      pend_vld <= post | (pend_vld & (done | tmo));
      if (post) pend <= is_abort ? 8'h5A : 8'hE1;
    end
  end

  assign bus.rx_clr   = rx_clr_q;
  assign bus.cmd      = cmd_q;
  assign bus.cmd_rdy  = cmd_rdy_q;
  assign bus.resp     = resp_q;
  assign bus.resp_vld = resp_vld_q;
  assign bus.fault    = fault_q;
  assign bus.occ      = occ_q;
endmodule
